// File: rtl/mont_pkg.sv
// Shared defaults and state types for the Montgomery modular-exponentiation controller.
package mont_pkg;

  localparam int unsigned WIDTH_DEFAULT     = 1024;
  localparam int unsigned EXP_WIDTH_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOMONT,
    S_SQUARE,
    S_MULT,
    S_FROMMONT,
    S_DONE
  } state_t;

  // Every multiplying state first issues the request, then waits for the product.
  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/exp_bit_scanner.sv
// Holds the captured exponent and walks its bit index MSB-first for the controller.
module exp_bit_scanner import mont_pkg::*; #(
  parameter  int unsigned EXP_WIDTH = EXP_WIDTH_DEFAULT,
  localparam int unsigned LW        = $clog2(EXP_WIDTH) + 1,
  localparam int unsigned IW        = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 dec,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LW-1:0]        in_elen,
  output logic                 cur_bit,
  output logic                 last,
  output logic                 empty
);

  logic [EXP_WIDTH-1:0] e_q;
  logic [IW-1:0]        idx;
  logic                 zero_len;
  logic [LW-1:0]        elen_clamped;

  assign elen_clamped = (in_elen > LW'(EXP_WIDTH)) ? LW'(EXP_WIDTH) : in_elen;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      idx      <= '0;
      zero_len <= 1'b0;
    end else if (load) begin
      e_q      <= in_e;
      idx      <= IW'(elen_clamped - LW'(1));
      zero_len <= (elen_clamped == '0);
    end else if (dec) begin
      idx <= idx - IW'(1);
    end
  end

  assign cur_bit = e_q[idx];
  assign last    = (idx == '0);
  assign empty   = zero_len;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
module mont_exp_ctrl import mont_pkg::*; #(
  parameter  int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter  int unsigned EXP_WIDTH = EXP_WIDTH_DEFAULT,
  localparam int unsigned LW        = $clog2(EXP_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LW-1:0]        in_elen,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH-1:0]     mul_result,
  input  logic                 mul_done
);

  state_t state, state_n;
  phase_t phase, phase_n;

  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] xt, xt_n;
  logic             load, dec, accept;
  logic             cur_bit, last, empty;

  exp_bit_scanner #(.EXP_WIDTH(EXP_WIDTH)) u_scanner (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .dec     (dec),
    .in_e    (in_e),
    .in_elen (in_elen),
    .cur_bit (cur_bit),
    .last    (last),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= PH_ISSUE;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    mul_start = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    dec       = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_TOMONT;
          phase_n = PH_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        if (phase == PH_ISSUE) begin
          mul_start = 1'b1;
          phase_n   = PH_WAIT;
        end else if (mul_done) begin
          accept  = 1'b1;
          phase_n = PH_ISSUE;
          case (state)
            S_TOMONT: state_n = empty ? S_FROMMONT : S_SQUARE;
            S_SQUARE: begin
              if (cur_bit) begin
                state_n = S_MULT;
              end else if (last) begin
                state_n = S_FROMMONT;
              end else begin
                dec     = 1'b1;
                state_n = S_SQUARE;
              end
            end
            S_MULT: begin
              if (last) begin
                state_n = S_FROMMONT;
              end else begin
                dec     = 1'b1;
                state_n = S_SQUARE;
              end
            end
            default: state_n = S_DONE;
          endcase
        end
      end
    endcase
  end

  // Product routing: TOMONT fills xt, every other multiply updates the accumulator.
  always_comb begin
    acc_n = acc;
    xt_n  = xt;
    if (state == S_TOMONT) begin
      xt_n = mul_result;
    end else begin
      acc_n = mul_result;
    end
  end

  // Next operands are registered together with the product so they are stable from ISSUE on.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      xt     <= '0;
      result <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      mul_m  <= '0;
    end else if (load) begin
      acc   <= in_r;
      xt    <= '0;
      mul_a <= in_x;
      mul_b <= in_r2;
      mul_m <= in_m;
    end else if (accept) begin
      acc   <= acc_n;
      xt    <= xt_n;
      mul_a <= acc_n;
      if (state == S_FROMMONT) begin
        result <= mul_result;
      end
      case (state_n)
        S_MULT:     mul_b <= xt_n;
        S_FROMMONT: mul_b <= WIDTH'(1);
        default:    mul_b <= acc_n;
      endcase
    end
  end

endmodule
